// File: rtl/aer_spike_encoder.sv
// Address-event transmitter: buffers parallel spike pulses in a pending bitmap and
// emits them one per cycle as (spike_out, addr_out) with round-robin arbitration.
module aer_spike_encoder #(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_SRC-1:0]  spikes_in,
  input  logic              step_in,
  input  logic              out_ready,
  output logic              spike_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              step_done,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              step_err
);

  localparam int unsigned IdxW    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned DropMax = (2 ** CNT_W) - 1;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e              state_q, state_d;
  logic [N_SRC-1:0]    pend_q, pend_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                spike_out_q, spike_out_d;
  logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
  logic                step_done_q, step_done_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                step_err_q, step_err_d;

  logic                slot_free;
  logic                found;
  logic                grant_en;
  logic [IdxW-1:0]     gnt_idx;
  logic [N_SRC-1:0]    grant;
  logic [N_SRC-1:0]    collide;
  int unsigned         idx;
  int unsigned         coll_cnt;
  int unsigned         drop_sum;

  assign slot_free = !spike_out_q || out_ready;

  // Round-robin search: first pending bit at or above rr_ptr, wrapping at N_SRC.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned j = 0; j < N_SRC; j++) begin
      idx = 32'(rr_ptr_q) + j;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && pend_q[IdxW'(idx)]) begin
        found   = 1'b1;
        gnt_idx = IdxW'(idx);
      end
    end
  end

  assign grant_en = slot_free && found;
  assign grant    = grant_en ? (N_SRC'(1) << gnt_idx) : '0;
  assign collide  = spikes_in & pend_q & ~grant;

  always_comb begin
    coll_cnt = 0;
    for (int unsigned i = 0; i < N_SRC; i++) coll_cnt = coll_cnt + 32'(collide[i]);
    drop_sum   = 32'(drop_cnt_q) + coll_cnt;
    drop_cnt_d = (drop_sum > DropMax) ? CNT_W'(DropMax) : CNT_W'(drop_sum);
  end

  always_comb begin
    pend_d      = (pend_q & ~grant) | spikes_in;
    rr_ptr_d    = rr_ptr_q;
    spike_out_d = spike_out_q;
    addr_out_d  = addr_out_q;
    if (grant_en) begin
      spike_out_d = 1'b1;
      addr_out_d  = ADDR_W'(gnt_idx);
      rr_ptr_d    = (32'(gnt_idx) == N_SRC - 1) ? '0 : gnt_idx + IdxW'(1);
    end else if (slot_free) begin
      spike_out_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    step_err_d  = step_err_q;
    unique case (state_q)
      StRun: begin
        if (step_in) state_d = StFlush;
      end
      StFlush: begin
        if (step_in) step_err_d = 1'b1;
        // Done once nothing is left to send and nothing new arrived this edge.
        if (slot_free && !grant_en && (pend_d == '0)) begin
          step_done_d = 1'b1;
          state_d     = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StRun;
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      spike_out_q <= 1'b0;
      addr_out_q  <= '0;
      step_done_q <= 1'b0;
      drop_cnt_q  <= '0;
      step_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      spike_out_q <= spike_out_d;
      addr_out_q  <= addr_out_d;
      step_done_q <= step_done_d;
      drop_cnt_q  <= drop_cnt_d;
      step_err_q  <= step_err_d;
    end
  end

  assign spike_out = spike_out_q;
  assign addr_out  = addr_out_q;
  assign step_done = step_done_q;
  assign busy      = (pend_q != '0) || spike_out_q;
  assign drop_cnt  = drop_cnt_q;
  assign step_err  = step_err_q;

endmodule
